// File: rtl/vga_sprite_fetch_if.sv
// Memory read port between the sprite fetcher (master) and the shared-memory
// arbiter (slave). Address is held with mem_req until mem_gnt; read data
// returns exactly one cycle after the granted cycle.
interface vga_sprite_fetch_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic [15:0]       mem_rdata;

    modport master (output mem_req, mem_addr, input  mem_gnt, mem_rdata);
    modport slave  (input  mem_req, mem_addr, output mem_gnt, mem_rdata);
endinterface

// File: rtl/vga_sprite_fetch.sv
// Per-frame sprite/attribute fetcher for the VGA bit generator.
// On frame_start, reads 8 words from BASE_ADDR.. into a fill buffer, then
// copies the whole fill buffer into the display buffer in one cycle so the
// VGA side never sees a mix of two frames. The display word is selected by
// a free-running 3-bit counter with no index latency.
module vga_sprite_fetch #(
    parameter int              ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                clk_50MHz,
    input  logic                clear,
    input  logic                frame_start,
    vga_sprite_fetch_if.master  mem,
    output logic [2:0]          vga_counter,
    output logic [15:0]         data_from_mem_vga,
    output logic                busy,
    output logic                overrun,
    input  logic                overrun_clr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t            state_q;
    logic [2:0]        issue_idx_q;
    logic [2:0]        rcv_idx_q;
    logic              gnt_last_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              busy_q;
    logic              overrun_q, overrun_d;
    logic [2:0]        vga_cnt_q;
    logic [7:0][15:0]  fill_q;
    logic [7:0][15:0]  disp_q;

    logic              start_fetch;
    logic              gnt_accept;
    logic              rcv_done;
    logic [2:0]        issue_idx_d;
    logic [ADDR_W-1:0] addr_d;

    // A fetch only starts from IDLE; frame_start anywhere else is an overrun.
    assign start_fetch = (state_q == IDLE) && frame_start;
    // A grant only counts while we are actually requesting.
    assign gnt_accept  = mem_req_q && mem.mem_gnt;
    // Eighth word lands on the coming edge.
    assign rcv_done    = gnt_last_q && (rcv_idx_q == 3'd7);
    assign issue_idx_d = issue_idx_q + 3'd1;
    // Address wraps modulo 2^ADDR_W past the top of memory.
    assign addr_d      = BASE_ADDR + ADDR_W'(issue_idx_d);

    // Fetch sequencer: issues 8 addresses, waits for the last word, commits.
    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) begin
            state_q     <= IDLE;
            issue_idx_q <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        state_q     <= REQ;
                        issue_idx_q <= '0;
                        mem_req_q   <= 1'b1;
                        mem_addr_q  <= BASE_ADDR;
                        busy_q      <= 1'b1;
                    end
                end
                REQ: begin
                    // Without a grant the address is held unchanged.
                    if (gnt_accept) begin
                        if (issue_idx_q == 3'd7) begin
                            state_q     <= WAIT;
                            issue_idx_q <= '0;
                            mem_req_q   <= 1'b0;
                            mem_addr_q  <= BASE_ADDR;
                        end else begin
                            issue_idx_q <= issue_idx_d;
                            mem_addr_q  <= addr_d;
                        end
                    end
                end
                WAIT: begin
                    if (rcv_done) state_q <= COMMIT;
                end
                COMMIT: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // Receive path: store the word returned one cycle after each grant.
    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) begin
            gnt_last_q <= 1'b0;
            rcv_idx_q  <= '0;
            fill_q     <= '0;
        end else begin
            gnt_last_q <= gnt_accept;
            if (start_fetch) begin
                rcv_idx_q <= '0;
            end else if (gnt_last_q) begin
                fill_q[rcv_idx_q] <= mem.mem_rdata;
                rcv_idx_q         <= rcv_idx_q + 3'd1;
            end
        end
    end

    // Display buffer: whole-block copy on the edge leaving COMMIT only.
    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear)                  disp_q <= '0;
        else if (state_q == COMMIT)  disp_q <= fill_q;
    end

    // Free-running word index for the VGA side.
    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) vga_cnt_q <= '0;
        else        vga_cnt_q <= vga_cnt_q + 3'd1;
    end

    // Overrun next state: a new overrun event beats a simultaneous clear.
    always_comb begin
        overrun_d = overrun_q;
        if (overrun_clr)                        overrun_d = 1'b0;
        if (frame_start && (state_q != IDLE))   overrun_d = 1'b1;
    end

    // Sticky overrun flag.
    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) overrun_q <= 1'b0;
        else        overrun_q <= overrun_d;
    end

    assign mem.mem_req       = mem_req_q;
    assign mem.mem_addr      = mem_addr_q;
    assign vga_counter       = vga_cnt_q;
    assign data_from_mem_vga = disp_q[vga_cnt_q];
    assign busy              = busy_q;
    assign overrun           = overrun_q;

endmodule

// File: tb/tb_vga_sprite_fetch.sv
// Bench for vga_sprite_fetch: two instances (base 0000 and FFFC) share the
// same frame_start / grant / clear stimulus. A transaction-level model tracks
// grants, the busy window, the display contents and the overrun flag.
module tb_vga_sprite_fetch;
    localparam logic [15:0] BASE0 = 16'h0000;
    localparam logic [15:0] BASE1 = 16'hFFFC;

    logic clk_50MHz = 1'b0;
    logic clear = 1'b0;
    logic frame_start = 1'b0;
    logic overrun_clr = 1'b0;
    always #10 clk_50MHz = ~clk_50MHz;

    vga_sprite_fetch_if #(.ADDR_W(16)) mif0 ();
    vga_sprite_fetch_if #(.ADDR_W(16)) mif1 ();

    logic [2:0]  vc0, vc1;
    logic [15:0] dat0, dat1;
    logic        bsy0, bsy1, ovr0, ovr1;

    vga_sprite_fetch #(.ADDR_W(16), .BASE_ADDR(BASE0)) dut0 (
        .clk_50MHz(clk_50MHz), .clear(clear), .frame_start(frame_start),
        .mem(mif0.master), .vga_counter(vc0), .data_from_mem_vga(dat0),
        .busy(bsy0), .overrun(ovr0), .overrun_clr(overrun_clr));

    vga_sprite_fetch #(.ADDR_W(16), .BASE_ADDR(BASE1)) dut1 (
        .clk_50MHz(clk_50MHz), .clear(clear), .frame_start(frame_start),
        .mem(mif1.master), .vga_counter(vc1), .data_from_mem_vga(dat1),
        .busy(bsy1), .overrun(ovr1), .overrun_clr(overrun_clr));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tg, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tg, got, exp, $time);
    endtask

    // Reference model state
    int          cyc;        // clock edges since reset release
    bit          act;        // a fetch is in progress (busy)
    int          ngnt;       // grants accepted in the current fetch
    int          cd;         // cycles left before commit once all grants are in
    bit          ovr_m;
    logic [15:0] disp_m [8];
    logic [15:0] new_tag;    // word i of the current fetch is new_tag+i
    // Decisions made at the previous negedge, taking effect at the edge between
    bit          p_start, p_acc_m, p_fs_busy, p_clr;
    bit          p_acc0, p_acc1;
    logic [15:0] p_addr0, p_addr1;

    task automatic model_clear();
        cyc = 0; act = 0; ngnt = 0; cd = 0; ovr_m = 0;
        for (int i = 0; i < 8; i++) disp_m[i] = 16'h0000;
        p_start = 0; p_acc_m = 0; p_fs_busy = 0; p_clr = 0;
        p_acc0 = 0; p_acc1 = 0;
    endtask

    task automatic chk_inst(input int k, input logic req, input logic [15:0] addr,
                            input logic [15:0] base, input logic [2:0] v,
                            input logic [15:0] d, input logic b, input logic o);
        logic [2:0]  v_exp;
        logic [15:0] a_exp;
        v_exp = 3'(cyc % 8);
        a_exp = base + 16'(ngnt);
        chk($sformatf("busy%0d", k), 32'(b), 32'(act));
        chk($sformatf("req%0d", k), 32'(req), 32'(act && ngnt < 8));
        if (act && ngnt < 8) chk($sformatf("addr%0d", k), 32'(addr), 32'(a_exp));
        chk($sformatf("vcnt%0d", k), 32'(v), 32'(v_exp));
        chk($sformatf("data%0d", k), 32'(d), 32'(disp_m[v_exp]));
        chk($sformatf("ovr%0d", k), 32'(o), 32'(ovr_m));
    endtask

    // One clock: update model for the edge just passed, check, drive next inputs.
    task automatic step(input bit g, input bit fs, input bit oc, input logic [15:0] tg);
        bit req_exp;
        @(negedge clk_50MHz);
        cyc++;
        if (act && ngnt == 8) begin
            if (cd == 0) begin
                for (int i = 0; i < 8; i++) disp_m[i] = new_tag + 16'(i);
                act = 0;
            end else cd--;
        end
        if (p_start) begin act = 1; ngnt = 0; end
        if (p_acc_m) begin
            ngnt++;
            if (ngnt == 8) cd = 1;
        end
        if (p_fs_busy) ovr_m = 1;
        else if (p_clr) ovr_m = 0;

        chk_inst(0, mif0.mem_req, mif0.mem_addr, BASE0, vc0, dat0, bsy0, ovr0);
        chk_inst(1, mif1.mem_req, mif1.mem_addr, BASE1, vc1, dat1, bsy1, ovr1);

        // Memory: data for a granted address one cycle later, junk otherwise.
        mif0.mem_rdata = p_acc0 ? new_tag + (p_addr0 - BASE0) : 16'($urandom);
        mif1.mem_rdata = p_acc1 ? new_tag + (p_addr1 - BASE1) : 16'($urandom);
        mif0.mem_gnt = g;
        mif1.mem_gnt = g;
        p_acc0 = mif0.mem_req && g; p_addr0 = mif0.mem_addr;
        p_acc1 = mif1.mem_req && g; p_addr1 = mif1.mem_addr;
        req_exp   = act && ngnt < 8;
        p_acc_m   = req_exp && g;
        frame_start = fs;
        overrun_clr = oc;
        p_start   = fs && !act;
        p_fs_busy = fs && act;
        p_clr     = oc;
        if (p_start) new_tag = tg;
    endtask

    // Async reset mid-cycle, check outputs immediately, release at a negedge.
    task automatic do_reset();
        @(negedge clk_50MHz);
        #3 clear = 1'b0;
        #1;
        chk("rst_vc0", 32'(vc0), 32'd0);   chk("rst_vc1", 32'(vc1), 32'd0);
        chk("rst_dat0", 32'(dat0), 32'd0); chk("rst_dat1", 32'(dat1), 32'd0);
        chk("rst_req0", 32'(mif0.mem_req), 32'd0);
        chk("rst_req1", 32'(mif1.mem_req), 32'd0);
        chk("rst_addr0", 32'(mif0.mem_addr), 32'(BASE0));
        chk("rst_addr1", 32'(mif1.mem_addr), 32'(BASE1));
        chk("rst_busy0", 32'(bsy0), 32'd0); chk("rst_busy1", 32'(bsy1), 32'd0);
        chk("rst_ovr0", 32'(ovr0), 32'd0);  chk("rst_ovr1", 32'(ovr1), 32'd0);
        @(negedge clk_50MHz);
        frame_start = 1'b0; overrun_clr = 1'b0;
        mif0.mem_gnt = 1'b0; mif1.mem_gnt = 1'b0;
        mif0.mem_rdata = 16'($urandom); mif1.mem_rdata = 16'($urandom);
        clear = 1'b1;
        model_clear();
    endtask

    initial begin
        new_tag = 16'h0000;
        mif0.mem_gnt = 1'b0; mif1.mem_gnt = 1'b0;
        mif0.mem_rdata = '0; mif1.mem_rdata = '0;
        model_clear();
        do_reset();

        // Basic fetch, grant always high
        step(1, 1, 0, 16'hA000);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 16'h0);

        // Alternate-cycle grant stalls, same content
        step(0, 1, 0, 16'hA000);
        for (int i = 0; i < 26; i++) step(i[0], 0, 0, 16'h0);

        // Atomic commit: long stall mid-fetch, old data must persist
        step(1, 1, 0, 16'hB000);
        for (int i = 0; i < 3; i++)  step(1, 0, 0, 16'h0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 16'h0);
        for (int i = 0; i < 14; i++) step(1, 0, 0, 16'h0);

        // Overrun during REQ, then clear, then clear coincident with new event
        step(1, 1, 0, 16'hC000);
        step(1, 0, 0, 16'h0);
        step(1, 1, 0, 16'hDEAD);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 16'h0);
        step(1, 0, 1, 16'h0);
        step(1, 0, 0, 16'h0);
        step(1, 1, 0, 16'hD000);
        step(1, 0, 0, 16'h0);
        step(1, 1, 1, 16'hBEEF);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 16'h0);
        step(1, 0, 1, 16'h0);
        step(1, 0, 0, 16'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++)
            step(($urandom % 4) != 0, ($urandom % 20) == 0, ($urandom % 16) == 0,
                 16'($urandom));

        // Reset in the middle of a fetch with a loaded display
        step(1, 1, 0, 16'hE000);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 16'h0);
        do_reset();
        for (int i = 0; i < 60; i++)
            step(($urandom % 3) != 0, ($urandom % 12) == 0, ($urandom % 16) == 0,
                 16'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
